// File: rtl/brightness_pwm_fade.sv
// ---------------------------------------------------------------------------
// brightness_pwm_fade
//
// Multi-channel PWM generator with per-period duty fading.
// A free-running PWM_W-bit period counter drives all channels. Each channel
// has a target duty, loaded from DATA_i on a CTS strobe. It also has an
// applied duty that moves toward the target only on the period wrap edge.
// That movement is either an immediate jump (fade_step_i = 0) or a bounded
// step of fade_step_i per period. The bounded step never overshoots the
// target.
//
// Ports
//   sys_clk            : single clock, all state on the rising edge
//   sys_resetb         : asynchronous active-low reset
//   DATA_i             : target duties, channel k at [k*PWM_W +: PWM_W]
//   CTS                : load strobe, DATA_i captured into targets when high
//   fade_step_i        : duty increment per period, 0 = jump to target
//   enable_i           : global run enable, counter held at 0 when low
//   DATA_Brightness_o  : currently applied duties, same packing as DATA_i
//   pwm_o              : registered PWM outputs, bit k = channel k
//   period_start_o     : high in cycles where counter = 0 and enable_i = 1
//   busy_o             : registered, high while any applied duty != target
//
// Parameter range: N_CH 1..32, PWM_W 4..12. STEP_W must not exceed PWM_W.
// ---------------------------------------------------------------------------
module brightness_pwm_fade #(
   parameter int N_CH   = 6,
   parameter int PWM_W  = 8,
   parameter int STEP_W = 4
) (
   input  logic                   sys_clk,
   input  logic                   sys_resetb,
   input  logic [N_CH*PWM_W-1:0]  DATA_i,
   input  logic                   CTS,
   input  logic [STEP_W-1:0]      fade_step_i,
   input  logic                   enable_i,
   output logic [N_CH*PWM_W-1:0]  DATA_Brightness_o,
   output logic [N_CH-1:0]        pwm_o,
   output logic                   period_start_o,
   output logic                   busy_o
);

   // One guard bit, so that applied +/- step can never wrap around.
   localparam int EXT_W = PWM_W + 1;

   localparam logic [PWM_W-1:0] CNT_MAX = {PWM_W{1'b1}};
   localparam logic [PWM_W-1:0] CNT_ONE = {{(PWM_W-1){1'b0}}, 1'b1};

   logic [PWM_W-1:0] counter_reg;
   logic [PWM_W-1:0] counter_next;
   logic             wrap;
   logic             step_zero;
   logic [EXT_W-1:0] step_ext;
   logic [N_CH-1:0]  pwm_reg;
   logic [N_CH-1:0]  pwm_next;
   logic [N_CH-1:0]  mismatch;
   logic             busy_reg;

   // ------------------------------------------------------------------
   // Period counter
   // ------------------------------------------------------------------
   always_comb begin
      counter_next = '0;
      if (enable_i) begin
         counter_next = counter_reg + CNT_ONE;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_resetb) begin
      if (!sys_resetb) begin
         counter_reg <= '0;
      end else begin
         counter_reg <= counter_next;
      end
   end

   // The applied duties move only on this edge.
   // fade_step_i is therefore sampled only here.
   assign wrap      = enable_i && (counter_reg == CNT_MAX);
   assign step_zero = (fade_step_i == '0);
   assign step_ext  = EXT_W'(fade_step_i);

   // Gated with the reset input so the pulse is low while reset is asserted.
   // The counter also sits at 0 during reset.
   assign period_start_o = sys_resetb && enable_i && (counter_reg == '0);

   // ------------------------------------------------------------------
   // Per-channel target / applied duty and PWM compare
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         logic [PWM_W-1:0] target_reg;
         logic [PWM_W-1:0] applied_reg;
         logic [PWM_W-1:0] applied_next;
         logic [EXT_W-1:0] app_ext;
         logic [EXT_W-1:0] tgt_ext;
         logic [EXT_W-1:0] up_sum;
         logic [EXT_W-1:0] down_diff;
         logic [EXT_W-1:0] down_limit;

         assign app_ext    = {1'b0, applied_reg};
         assign tgt_ext    = {1'b0, target_reg};
         assign up_sum     = app_ext + step_ext;
         assign down_diff  = app_ext - step_ext;
         // A downward step stays at or above the target only when
         // applied >= target + step. Otherwise the step clamps to the target.
         assign down_limit = tgt_ext + step_ext;

         always_comb begin
            applied_next = applied_reg;
            if (wrap) begin
               if (step_zero) begin
                  applied_next = target_reg;
               end else if (tgt_ext > app_ext) begin
                  applied_next = (up_sum >= tgt_ext) ? target_reg : up_sum[PWM_W-1:0];
               end else if (tgt_ext < app_ext) begin
                  applied_next = (app_ext >= down_limit) ? down_diff[PWM_W-1:0] : target_reg;
               end
            end
         end

         // On a CTS edge that coincides with a wrap, the old target is used:
         // applied_next is computed from target_reg before the load.
         always_ff @(posedge sys_clk or negedge sys_resetb) begin
            if (!sys_resetb) begin
               target_reg  <= '0;
               applied_reg <= '0;
            end else begin
               if (CTS) begin
                  target_reg <= DATA_i[gi*PWM_W +: PWM_W];
               end
               applied_reg <= applied_next;
            end
         end

         assign pwm_next[gi] = enable_i && (counter_reg < applied_reg);
         assign mismatch[gi] = (applied_reg != target_reg);
         assign DATA_Brightness_o[gi*PWM_W +: PWM_W] = applied_reg;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge sys_clk or negedge sys_resetb) begin
      if (!sys_resetb) begin
         pwm_reg  <= '0;
         busy_reg <= 1'b0;
      end else begin
         pwm_reg  <= pwm_next;
         busy_reg <= |mismatch;
      end
   end

   assign pwm_o  = pwm_reg;
   assign busy_o = busy_reg;

endmodule

// File: tb/tb_brightness_pwm_fade.sv
// ---------------------------------------------------------------------------
// tb_brightness_pwm_fade
//
// Directed bench for brightness_pwm_fade (N_CH=6, PWM_W=8, STEP_W=4).
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_brightness_pwm_fade;

   localparam int N_CH   = 6;
   localparam int PWM_W  = 8;
   localparam int STEP_W = 4;

   logic                  sys_clk = 1'b0;
   logic                  sys_resetb;
   logic [N_CH*PWM_W-1:0] DATA_i;
   logic                  CTS;
   logic [STEP_W-1:0]     fade_step_i;
   logic                  enable_i;
   logic [N_CH*PWM_W-1:0] DATA_Brightness_o;
   logic [N_CH-1:0]       pwm_o;
   logic                  period_start_o;
   logic                  busy_o;

   int checks_cnt = 0;
   int errors_cnt = 0;

   always #5 sys_clk = ~sys_clk;

   brightness_pwm_fade #(
      .N_CH   (N_CH),
      .PWM_W  (PWM_W),
      .STEP_W (STEP_W)
   ) dut (
      .sys_clk           (sys_clk),
      .sys_resetb        (sys_resetb),
      .DATA_i            (DATA_i),
      .CTS               (CTS),
      .fade_step_i       (fade_step_i),
      .enable_i          (enable_i),
      .DATA_Brightness_o (DATA_Brightness_o),
      .pwm_o             (pwm_o),
      .period_start_o    (period_start_o),
      .busy_o            (busy_o)
   );

   task automatic check_value(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks_cnt++;
      if (actual !== expected) begin
         errors_cnt++;
         $display("FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end else begin
         $display("ok   %s value=%0h", tag, actual);
      end
   endtask

   // Advance to the next negedge where period_start_o is high, which means the
   // counter is 0. The preceding posedge was the wrap edge.
   task automatic wait_wrap();
      int n;
      n = 0;
      @(negedge sys_clk);
      while (period_start_o !== 1'b1 && n < 600) begin
         @(negedge sys_clk);
         n++;
      end
      if (n >= 600) check_value("wrap_timeout", 64'(period_start_o), 64'h1);
   endtask

   // Strobe CTS for one cycle with the given data and step.
   task automatic load(input logic [N_CH*PWM_W-1:0] d, input logic [STEP_W-1:0] s);
      DATA_i      = d;
      fade_step_i = s;
      CTS         = 1'b1;
      @(negedge sys_clk);
      CTS         = 1'b0;
   endtask

   // Count high samples over one full period.
   // The count is for channel 0 and for any of channels 5..1.
   task automatic count_period(output int c0, output int crest);
      c0    = 0;
      crest = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge sys_clk);
         if (pwm_o[0]) c0++;
         if (pwm_o[N_CH-1:1] != '0) crest++;
      end
   endtask

   initial begin
      int c0;
      int crest;

      sys_resetb  = 1'b0;
      enable_i    = 1'b1;
      CTS         = 1'b0;
      DATA_i      = '0;
      fade_step_i = '0;

      // Reset state, with enable held high during reset
      repeat (3) @(negedge sys_clk);
      check_value("rst_bright", 64'(DATA_Brightness_o), 64'h0);
      check_value("rst_pwm",    64'(pwm_o),             64'h0);
      check_value("rst_pstart", 64'(period_start_o),    64'h0);
      check_value("rst_busy",   64'(busy_o),            64'h0);

      // First period start is in the first enabled cycle after release
      sys_resetb = 1'b1;
      #1;
      check_value("first_pstart", 64'(period_start_o), 64'h1);

      // ch0 = 0x40, step 0
      load(48'h0000_0000_0040, 4'd0);
      @(negedge sys_clk);
      check_value("busy_after_load",  64'(busy_o),            64'h1);
      check_value("bright_before_wr", 64'(DATA_Brightness_o), 64'h0);
      wait_wrap();
      check_value("bright_40", 64'(DATA_Brightness_o), 64'h40);
      count_period(c0, crest);
      check_value("duty40_ch0",  64'(c0),             64'd64);
      check_value("duty40_rest", 64'(crest),          64'd0);
      check_value("pstart_256",  64'(period_start_o), 64'h1);
      check_value("busy_idle",   64'(busy_o),         64'h0);

      // Preset ch0 = 0x00, ch1 = 0x0A
      load(48'h0000_0000_0A00, 4'd0);
      wait_wrap();
      check_value("preset", 64'(DATA_Brightness_o), 64'h0A00);

      // Fade ch0 up to 0x10 and ch1 down to 0x00 with step 4
      load(48'h0000_0000_0010, 4'd4);
      wait_wrap();
      check_value("fade_1", 64'(DATA_Brightness_o), 64'h0604);
      wait_wrap();
      check_value("fade_2", 64'(DATA_Brightness_o), 64'h0208);
      wait_wrap();
      check_value("fade_3", 64'(DATA_Brightness_o), 64'h000C);
      wait_wrap();
      check_value("fade_4",      64'(DATA_Brightness_o), 64'h0010);
      check_value("fade_busy_1", 64'(busy_o),            64'h1);
      @(negedge sys_clk);
      check_value("fade_busy_0", 64'(busy_o),            64'h0);

      // CTS coincident with the wrap edge; the counter is at 1 here
      repeat (254) @(negedge sys_clk);
      DATA_i      = 48'h0000_0000_0080;
      fade_step_i = 4'd0;
      CTS         = 1'b1;
      @(negedge sys_clk);
      CTS         = 1'b0;
      check_value("ctswrap_pstart", 64'(period_start_o),    64'h1);
      check_value("ctswrap_old",    64'(DATA_Brightness_o), 64'h10);
      wait_wrap();
      check_value("ctswrap_new",    64'(DATA_Brightness_o), 64'h80);

      // Full duty 0xFF on ch0, 0 elsewhere
      load(48'h0000_0000_00FF, 4'd0);
      wait_wrap();
      check_value("bright_ff", 64'(DATA_Brightness_o), 64'hFF);
      count_period(c0, crest);
      check_value("dutyff_ch0",  64'(c0),    64'd255);
      check_value("dutyff_rest", 64'(crest), 64'd0);

      // Enable dropped mid-period, then restored
      repeat (20) @(negedge sys_clk);
      enable_i = 1'b0;
      @(negedge sys_clk);
      check_value("dis_pwm",    64'(pwm_o),          64'h0);
      check_value("dis_pstart", 64'(period_start_o), 64'h0);
      repeat (5) @(negedge sys_clk);
      check_value("dis_retain", 64'(DATA_Brightness_o), 64'hFF);
      enable_i = 1'b1;
      #1;
      check_value("reen_pstart", 64'(period_start_o), 64'h1);

      // Asynchronous reset mid-period with all channels on
      load(48'hFFFF_FFFF_FFFF, 4'd0);
      wait_wrap();
      repeat (10) @(negedge sys_clk);
      check_value("all_on_pwm", 64'(pwm_o), 64'h3F);
      #2;
      sys_resetb = 1'b0;
      #1;
      check_value("async_pwm",    64'(pwm_o),             64'h0);
      check_value("async_bright", 64'(DATA_Brightness_o), 64'h0);
      check_value("async_busy",   64'(busy_o),            64'h0);
      check_value("async_pstart", 64'(period_start_o),    64'h0);
      @(negedge sys_clk);
      sys_resetb = 1'b1;
      #1;
      check_value("post_rst_pstart", 64'(period_start_o), 64'h1);
      @(negedge sys_clk);
      check_value("post_rst_cnt1", 64'(period_start_o), 64'h0);
      check_value("post_rst_pwm",  64'(pwm_o),          64'h0);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule

// File: doc/brightness_pwm_fade.md
BRIGHTNESS_PWM_FADE -- requirements
Module: brightness_pwm_fade

Interface
REQ-001 Parameter N_CH, default 6, number of PWM channels (1..32).
REQ-002 Parameter PWM_W, default 8, duty and counter resolution in bits (4..12).
REQ-003 Parameter STEP_W, default 4, width of fade step input.
REQ-004 sys_clk  input  1  single clock; all state on rising edge.
REQ-005 sys_resetb  input  1  asynchronous, active-low reset.
REQ-006 DATA_i  input  N_CH*PWM_W  target duties; channel k at [k*PWM_W +: PWM_W].
REQ-007 CTS  input  1  load strobe; DATA_i captured as target when high.
REQ-008 fade_step_i  input  STEP_W  per-period duty increment; 0 = immediate jump.
REQ-009 enable_i  input  1  global run enable.
REQ-010 DATA_Brightness_o  output  N_CH*PWM_W  currently applied duties, same packing as DATA_i.
REQ-011 pwm_o  output  N_CH  registered PWM outputs, bit k = channel k.
REQ-012 period_start_o  output  1  one-cycle pulse at start of each PWM period.
REQ-013 busy_o  output  1  registered; high while any applied duty differs from its target.

Function
REQ-014 PWM_W-bit counter SHALL increment by 1 per cycle while enable_i=1, wrapping 2^PWM_W-1 -> 0.
REQ-015 While enable_i=0, counter SHALL be held at 0, pwm_o SHALL be 0 from next cycle, and applied/target duties SHALL be retained.
REQ-016 period_start_o SHALL be 1 in exactly the cycles where counter=0 and enable_i=1.
REQ-017 On an edge with CTS=1, all N_CH target registers SHALL load DATA_i; CTS=0 holds targets.
REQ-018 Applied duties (DATA_Brightness_o) SHALL change only on the wrap edge (counter=2^PWM_W-1, enable_i=1).
REQ-019 At wrap with fade_step_i=0: applied[k] <= target[k].
REQ-020 At wrap with fade_step_i=s>0: if target>applied, applied <= min(applied+s, target); if target<applied, applied <= max(applied-s, target); else hold.
REQ-021 Fade arithmetic SHALL use PWM_W+1 bits internally; no wrap-around, no overshoot past target.
REQ-022 CTS coincident with a wrap edge: fade step SHALL use the pre-edge target; new target takes effect at the following wrap.
REQ-023 pwm_o[k] SHALL be registered as (counter < applied[k]), one cycle latency from counter value.
REQ-024 Duty 0 SHALL give pwm_o[k] constantly 0; duty 2^PWM_W-1 SHALL give high 2^PWM_W-1 of 2^PWM_W cycles.
REQ-025 busy_o SHALL be registered from (any applied[k] != target[k]) with one cycle latency.
REQ-026 enable_i deasserted mid-period then reasserted SHALL restart a full period from counter=0 with a period_start_o pulse.
REQ-027 fade_step_i SHALL be sampled only at wrap edges; changes mid-period have no effect until then.

Reset
REQ-028 sys_resetb=0 SHALL asynchronously clear counter, targets, applied duties, pwm_o, period_start_o and busy_o to 0.
REQ-029 Reset asserted mid-period or mid-fade SHALL abort immediately; after release, operation restarts from counter=0 with all duties 0.
REQ-030 First period_start_o after release SHALL occur in the first cycle with enable_i=1.

Verification (N_CH=6, PWM_W=8, STEP_W=4)
REQ-031 Reset, enable_i=1, CTS 1 cycle, ch0 DATA=0x40, step=0 -> after next wrap pwm_o[0] high 64 of every 256 cycles, pwm_o[5:1]=0.
REQ-032 Applied ch0=0x00, target 0x10, step=4 -> applied 0x04,0x08,0x0C,0x10 at four successive wraps; busy_o falls one cycle after 0x10.
REQ-033 Applied ch1=0x0A, target 0x00, step=4 -> applied 0x06,0x02,0x00; no underflow.
REQ-034 Duties 0x00 and 0xFF -> pwm_o constant 0, and low exactly 1 cycle per 256 respectively.
REQ-035 CTS with new target on wrap edge, step=0 -> applied keeps old value that period, new value after next wrap.
REQ-036 sys_resetb pulsed low mid-period with pwm_o=6'h3F -> all outputs 0 without waiting for a clock edge; counter restarts at 0.
